peripheral_uart_receiver_wb: RTL and testbench

//  UART serial receiver, directly upstream of the receive FIFO.

---
 rtl/peripheral_uart_pkg.sv | 34 +++
 rtl/peripheral_uart_sync_wb.sv | 21 ++
 rtl/peripheral_uart_receiver_wb.sv | 136 +++++++++++++
 tb/tb_peripheral_uart_receiver_wb.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/peripheral_uart_pkg.sv
// Shared types and constants for the UART receive path.
// Used by peripheral_uart_receiver_wb and its synchroniser.
package peripheral_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    PUSH,
    WAIT_HIGH
  } rx_state_t;

  // Line control register bit positions
  localparam int LCR_WL_LSB = 0;
  localparam int LCR_WL_MSB = 1;
  localparam int LCR_STB    = 2;
  localparam int LCR_PEN    = 3;
  localparam int LCR_EPS    = 4;
  localparam int LCR_SP     = 5;

  // Flag positions in the low bits of the FIFO word
  localparam int FLAG_BRK = 2;
  localparam int FLAG_PE  = 1;
  localparam int FLAG_FE  = 0;

  // Bits on the wire per character: start + data + parity + stop(s), range 7..12.
  function automatic logic [3:0] frame_bits(input logic [7:0] lcr);
    return 4'd7 + {2'b00, lcr[LCR_WL_MSB:LCR_WL_LSB]}
                + {3'b000, lcr[LCR_PEN]} + {3'b000, lcr[LCR_STB]};
  endfunction

endpackage

// File: rtl/peripheral_uart_sync_wb.sv
// Multi-flop synchroniser for the serial input; resets to the line idle level (1).
module peripheral_uart_sync_wb #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) sr <= '1;
    else          sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/peripheral_uart_receiver_wb.sv
// UART receiver: 16x oversampled deframer that pushes {data, break, pe, fe} words to the RX FIFO.
// Optional character timeout is built when PERIPHERAL_UART_RX_TIMEOUT_EN is defined.
module peripheral_uart_receiver_wb
  import peripheral_uart_pkg::*;
#(
  parameter int FIFO_WIDTH     = 11,
  parameter int FIFO_COUNTER_W = 5,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic                      enable,
  input  logic                      srx_pad_i,
  input  logic [7:0]                lcr,
  input  logic [FIFO_COUNTER_W-1:0] rf_count,
  input  logic                      rf_pop,
  output logic                      rf_push,
  output logic [FIFO_WIDTH-1:0]     rf_data_in,
  output logic                      rx_busy,
  output logic                      timeout_o
);

  logic      srx_s;
  rx_state_t state, state_next;
  logic [3:0] tick;
  logic [2:0] bit_cnt;
  logic [7:0] data;
  logic [7:0] lcr_q;
  logic       pe_q, fe_q, brk_q, par_q;
  logic       sample_mid;
  logic [2:0] last_bit;
  logic       par_expected;

  peripheral_uart_sync_wb #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .d        (srx_pad_i),
    .q        (srx_s)
  );

  assign sample_mid   = enable && (tick == 4'hF);
  // Word length 5..8 maps to last bit index 4..7.
  assign last_bit     = {1'b1, lcr_q[LCR_WL_MSB:LCR_WL_LSB]};
  assign par_expected = lcr_q[LCR_SP] ? ~lcr_q[LCR_EPS] : ((^data) ^ ~lcr_q[LCR_EPS]);

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (enable && !srx_s) state_next = START;
      START:     if (enable && tick == 4'd7) state_next = srx_s ? IDLE : DATA;
      DATA:      if (sample_mid && bit_cnt == last_bit)
                   state_next = lcr_q[LCR_PEN] ? PARITY : STOP;
      PARITY:    if (sample_mid) state_next = STOP;
      STOP:      if (sample_mid) state_next = PUSH;
      PUSH:      state_next = brk_q ? WAIT_HIGH : IDLE;
      WAIT_HIGH: if (enable && srx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tick    <= '0;
      bit_cnt <= '0;
      data    <= '0;
      lcr_q   <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      if (enable) tick <= tick + 4'd1;
      case (state)
        IDLE: if (enable && !srx_s) tick <= '0;
        START: if (enable && tick == 4'd7 && !srx_s) begin
          // Start bit confirmed: latch line format and clear the previous character.
          tick    <= '0;
          bit_cnt <= '0;
          data    <= '0;
          lcr_q   <= lcr;
          pe_q    <= 1'b0;
          fe_q    <= 1'b0;
          brk_q   <= 1'b0;
          par_q   <= 1'b0;
        end
        DATA: if (sample_mid) begin
          data[bit_cnt] <= srx_s;
          bit_cnt       <= bit_cnt + 3'd1;
        end
        PARITY: if (sample_mid) begin
          par_q <= srx_s;
          pe_q  <= srx_s ^ par_expected;
        end
        STOP: if (sample_mid) begin
          fe_q  <= ~srx_s;
          brk_q <= ~srx_s && (data == 8'h00) && (!lcr_q[LCR_PEN] || !par_q);
        end
        default: ;
      endcase
    end
  end

  assign rf_push    = (state == PUSH);
  assign rf_data_in = FIFO_WIDTH'({data, brk_q, pe_q, fe_q});
  assign rx_busy    = (state != IDLE);

`ifdef PERIPHERAL_UART_RX_TIMEOUT_EN
  logic [9:0] counter_t;
  logic [9:0] toc;
  logic       unused_lcr_bits;

  assign toc = {frame_bits(lcr), 6'b000000};

  // Reset to a non-zero value so timeout_o is low out of reset whatever rf_count is.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i)                                 counter_t <= '1;
    else if (rf_push || rf_pop || rf_count == '0) counter_t <= toc;
    else if (enable && counter_t != '0)           counter_t <= counter_t - 10'd1;
  end

  assign timeout_o       = (counter_t == '0) && (rf_count != '0);
  assign unused_lcr_bits = ^lcr[7:6];
`else
  logic unused_timeout_inputs;

  assign timeout_o             = 1'b0;
  assign unused_timeout_inputs = ^{rf_count, rf_pop, lcr[7:6]};
`endif

endmodule

// File: tb/tb_peripheral_uart_receiver_wb.sv
// Directed bench for peripheral_uart_receiver_wb; define PERIPHERAL_UART_RX_TIMEOUT_EN to cover the timeout.
module tb_peripheral_uart_receiver_wb;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        enable = 1'b0;
  logic        srx_pad_i;
  logic [7:0]  lcr;
  logic [4:0]  rf_count;
  logic        rf_pop;
  logic        rf_push;
  logic [10:0] rf_data_in;
  logic        rx_busy;
  logic        timeout_o;

  int errors = 0;
  int checks = 0;
  int push_cnt = 0;
  int push_base;
  int en_cnt = 0;
  logic [10:0] last_word = '0;

  peripheral_uart_receiver_wb dut (
    .clk        (clk),
    .wb_rst_i   (wb_rst_i),
    .enable     (enable),
    .srx_pad_i  (srx_pad_i),
    .lcr        (lcr),
    .rf_count   (rf_count),
    .rf_pop     (rf_pop),
    .rf_push    (rf_push),
    .rf_data_in (rf_data_in),
    .rx_busy    (rx_busy),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  // 16x baud enable: one clk in every four.
  always @(negedge clk) begin
    en_cnt = (en_cnt + 1) % 4;
    enable = (en_cnt == 0);
  end

  always @(negedge clk) begin
    if (rf_push) begin
      push_cnt++;
      last_word = rf_data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic hold_bit();
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                            input logic par, input logic stop);
    srx_pad_i = 1'b0;
    hold_bit();
    for (int i = 0; i < nbits; i++) begin
      srx_pad_i = d[i];
      hold_bit();
    end
    if (has_par) begin
      srx_pad_i = par;
      hold_bit();
    end
    srx_pad_i = stop;
    hold_bit();
    srx_pad_i = 1'b1;
  endtask

  initial begin
    wb_rst_i  = 1'b1;
    srx_pad_i = 1'b1;
    lcr       = 8'h03;
    rf_count  = '0;
    rf_pop    = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_push", rf_push, 0);
    check("reset_data", rf_data_in, 0);
    check("reset_busy", rx_busy, 0);
    check("reset_timeout", timeout_o, 0);
    wb_rst_i = 1'b0;
    repeat (20) @(negedge clk);

    // 1: 0xA5 8N1
    push_base = push_cnt;
    fork
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
      begin
        repeat (200) @(negedge clk);
        check("t1_busy_mid", rx_busy, 1);
      end
    join
    check("t1_pushes", push_cnt - push_base, 1);
    check("t1_word", last_word, {8'hA5, 3'b000});
    check("t1_busy_after", rx_busy, 0);
    repeat (100) @(negedge clk);

    // 2: 0x07 8E1 with parity bit 0 (even parity expects 1)
    lcr = 8'h1B;
    push_base = push_cnt;
    send_frame(8'h07, 8, 1'b1, 1'b0, 1'b1);
    check("t2_pushes", push_cnt - push_base, 1);
    check("t2_word", last_word, {8'h07, 3'b010});
    repeat (100) @(negedge clk);

    // 3: 0x1F 5N1 with stop bit 0
    lcr = 8'h00;
    push_base = push_cnt;
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    check("t3_pushes", push_cnt - push_base, 1);
    check("t3_word", last_word, {8'h1F, 3'b001});
    check("t3_busy_after", rx_busy, 0);

    // 4: line held low two frame times at 8N1 -> one break character
    lcr = 8'h03;
    push_base = push_cnt;
    srx_pad_i = 1'b0;
    repeat (1280) @(negedge clk);
    check("t4_pushes_low", push_cnt - push_base, 1);
    check("t4_word", last_word, {8'h00, 3'b101});
    check("t4_busy_low", rx_busy, 1);
    srx_pad_i = 1'b1;
    repeat (200) @(negedge clk);
    check("t4_pushes_high", push_cnt - push_base, 1);
    check("t4_busy_high", rx_busy, 0);

    // 5a: low glitch of 6 enable ticks
    push_base = push_cnt;
    srx_pad_i = 1'b0;
    repeat (24) @(negedge clk);
    srx_pad_i = 1'b1;
    repeat (200) @(negedge clk);
    check("t5_glitch_pushes", push_cnt - push_base, 0);
    check("t5_glitch_busy", rx_busy, 0);

    // 5b: reset during data bits discards the character
    push_base = push_cnt;
    srx_pad_i = 1'b0;
    repeat (150) @(negedge clk);
    check("t5_busy_in_data", rx_busy, 1);
    wb_rst_i = 1'b1;
    @(negedge clk);
    check("t5_busy_reset", rx_busy, 0);
    check("t5_push_reset", rf_push, 0);
    srx_pad_i = 1'b1;
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b0;
    repeat (800) @(negedge clk);
    check("t5_reset_pushes", push_cnt - push_base, 0);
    check("t5_reset_busy", rx_busy, 0);

    // 6: character timeout
    lcr = 8'h03;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    check("t6_word", last_word, {8'h3C, 3'b000});
    rf_count = 5'd1;
`ifdef PERIPHERAL_UART_RX_TIMEOUT_EN
    repeat (2400) @(negedge clk);
    check("t6_timeout_early", timeout_o, 0);
    repeat (200) @(negedge clk);
    check("t6_timeout_set", timeout_o, 1);
    rf_pop = 1'b1;
    @(negedge clk);
    rf_pop = 1'b0;
    check("t6_timeout_cleared", timeout_o, 0);
`else
    repeat (2600) @(negedge clk);
    check("t6_timeout_off", timeout_o, 0);
`endif
    rf_count = '0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
